// File: rtl/gals_producer_if.sv
// Bundles the burst request inputs, the FIFO write port and the status outputs of gals_producer.
// The producer uses modport master; the environment or testbench uses slave.
interface gals_producer_if;
  logic        start;
  logic [7:0]  burst_len;
  logic        pattern_sel;
  logic [15:0] seed;
  logic        buffer_full;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        busy;
  logic        done;
  logic [15:0] words_sent;

  modport master (
    input  start, burst_len, pattern_sel, seed, buffer_full,
    output data_1_en, data_1, busy, done, words_sent
  );

  modport slave (
    output start, burst_len, pattern_sel, seed, buffer_full,
    input  data_1_en, data_1, busy, done, words_sent
  );
endinterface

// File: rtl/gals_producer.sv
// Burst producer feeding the write side of the GALS FIFO: header, payload (incrementing or LFSR), optional trailer.
// Define PRODUCER_CHECKSUM_EN to append an XOR checksum trailer word to every burst.
module gals_producer (
  input  logic            clock_1,
  input  logic            reset,
  gals_producer_if.master prod_if
);

  localparam logic [7:0] HDR_TAG    = 8'hA5;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
`ifdef PRODUCER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECKSUM = 3'd3;
`endif
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [15:0] pat_q, pat_d;
`ifdef PRODUCER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
  logic [15:0] trailer;
`endif

  logic        accept;
  logic        end_burst;
  logic [15:0] pat_next;
  logic [15:0] header_word;
  logic [15:0] first_word;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign accept      = en_q && !prod_if.buffer_full;
  assign pat_next    = mode_q ? lfsr_step(pat_q) : pat_q + 16'd1;
  assign header_word = {HDR_TAG, prod_if.burst_len};
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1 in LFSR mode.
  assign first_word  = (prod_if.pattern_sel && (prod_if.seed == 16'h0000)) ? 16'h0001 : prod_if.seed;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    en_d      = en_q;
    done_d    = 1'b0;
    words_d   = words_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pat_d     = pat_q;
    end_burst = 1'b0;
`ifdef PRODUCER_CHECKSUM_EN
    csum_d    = csum_q;
    trailer   = csum_q;
`endif

    if (accept) begin
      words_d = words_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (prod_if.start) begin
          len_d   = prod_if.burst_len;
          mode_d  = prod_if.pattern_sel;
          pat_d   = first_word;
          data_d  = header_word;
          en_d    = 1'b1;
          state_d = ST_HEADER;
`ifdef PRODUCER_CHECKSUM_EN
          csum_d  = header_word;
`endif
        end
      end

      ST_HEADER: begin
        if (accept) begin
          if (len_q != 8'd0) begin
            state_d = ST_PAYLOAD;
            data_d  = pat_q;
            pat_d   = pat_next;
            cnt_d   = 8'd0;
          end else begin
            end_burst = 1'b1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
`ifdef PRODUCER_CHECKSUM_EN
          csum_d  = csum_q ^ data_q;
          trailer = csum_q ^ data_q;
`endif
          if (cnt_q == len_q - 8'd1) begin
            end_burst = 1'b1;
          end else begin
            data_d = pat_q;
            pat_d  = pat_next;
          end
        end
      end

`ifdef PRODUCER_CHECKSUM_EN
      ST_CHECKSUM: begin
        if (accept) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          data_d  = 16'h0000;
          done_d  = 1'b1;
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        data_d  = 16'h0000;
      end
    endcase

    if (end_burst) begin
`ifdef PRODUCER_CHECKSUM_EN
      state_d = ST_CHECKSUM;
      data_d  = trailer;
`else
      state_d = ST_DONE;
      en_d    = 1'b0;
      data_d  = 16'h0000;
      done_d  = 1'b1;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= 16'h0000;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      words_q <= 16'h0000;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      mode_q  <= 1'b0;
      pat_q   <= 16'h0000;
`ifdef PRODUCER_CHECKSUM_EN
      csum_q  <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      words_q <= words_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
`ifdef PRODUCER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign prod_if.data_1_en  = en_q;
  assign prod_if.data_1     = data_q;
  assign prod_if.busy       = busy_q;
  assign prod_if.done       = done_q;
  assign prod_if.words_sent = words_q;

endmodule
